// File: rtl/switch_clock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : switch_clock_ctrl
//  Description : Runtime-configurable sequencer for the complementary switch
//                clocks Fsw / Fsw_bar. Half-period and dead-time arrive
//                through a valid/ready slot and take effect on period
//                boundaries. Stopping always completes the running period.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_clock_ctrl #(
    parameter int HALF_W   = 6,
    parameter int DEAD_W   = 3,
    parameter int DEF_HALF = 50,
    parameter int DEF_DEAD = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [HALF_W-1:0] cfg_half,
    input  logic [DEAD_W-1:0] cfg_dead,
    output logic              Fsw,
    output logic              Fsw_bar,
    output logic              busy,
    output logic              period_tick,
    output logic              cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DEAD1 = 3'd1,
        S_PHA   = 3'd2,
        S_DEAD2 = 3'd3,
        S_PHB   = 3'd4
    } state_t;

    localparam logic [HALF_W-1:0] ONE = HALF_W'(1);

    state_t            state, state_nxt;
    logic [HALF_W-1:0] cnt, cnt_nxt;

    // Active configuration drives the running period; pending is the slot.
    logic [HALF_W-1:0] act_half;
    logic [DEAD_W-1:0] act_dead;
    logic [HALF_W-1:0] pend_half;
    logic [DEAD_W-1:0] pend_dead;
    logic              pend_full;

    logic              xfer;
    logic              cfg_ok;
    logic              expire;
    logic              start;
    logic              apply;
    logic [HALF_W-1:0] eff_half;
    logic [HALF_W-1:0] eff_dead;
    logic [HALF_W-1:0] act_dead_ext;

    assign cfg_ready    = ~pend_full;
    assign xfer         = cfg_valid & ~pend_full;
    assign act_dead_ext = {{(HALF_W-DEAD_W){1'b0}}, act_dead};
    // H >= 2 and D < H keeps every phase duration at least one cycle.
    assign cfg_ok       = (cfg_half >= HALF_W'(2)) &&
                          ({{(HALF_W-DEAD_W){1'b0}}, cfg_dead} < cfg_half);
    // Counter holds remaining cycles minus one; zero means last cycle.
    assign expire       = (cnt == '0);

    // Next-state, duration load and boundary decisions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = expire ? cnt : cnt - ONE;
        start     = 1'b0;
        apply     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = cnt;
                apply   = pend_full;
                start   = en;
            end
            S_DEAD1: begin
                if (expire) begin
                    state_nxt = S_PHA;
                    cnt_nxt   = act_half - act_dead_ext - ONE;
                end
            end
            S_PHA: begin
                if (expire) begin
                    if (act_dead == '0) begin
                        state_nxt = S_PHB;
                        cnt_nxt   = act_half - ONE;
                    end else begin
                        state_nxt = S_DEAD2;
                        cnt_nxt   = act_dead_ext - ONE;
                    end
                end
            end
            S_DEAD2: begin
                if (expire) begin
                    state_nxt = S_PHB;
                    cnt_nxt   = act_half - act_dead_ext - ONE;
                end
            end
            S_PHB: begin
                if (expire) begin
                    if (en) begin
                        apply = pend_full;
                        start = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // A new period uses the config that becomes active on this edge.
        eff_half = apply ? pend_half : act_half;
        eff_dead = apply ? {{(HALF_W-DEAD_W){1'b0}}, pend_dead} : act_dead_ext;
        if (start) begin
            if (eff_dead == '0) begin
                state_nxt = S_PHA;
                cnt_nxt   = eff_half - ONE;
            end else begin
                state_nxt = S_DEAD1;
                cnt_nxt   = eff_dead - ONE;
            end
        end
    end

    // State and duration counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs decoded from next state, so they are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Fsw         <= 1'b0;
            Fsw_bar     <= 1'b0;
            busy        <= 1'b0;
            period_tick <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            Fsw         <= (state_nxt == S_PHA);
            Fsw_bar     <= (state_nxt == S_PHB);
            busy        <= (state_nxt != S_IDLE);
            period_tick <= start;
            cfg_err     <= xfer & ~cfg_ok;
        end
    end

    // Config slot fill and promotion to active. Fill and promotion never
    // coincide: filling needs an empty slot, promotion a full one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_half  <= HALF_W'(DEF_HALF);
            act_dead  <= DEAD_W'(DEF_DEAD);
            pend_half <= '0;
            pend_dead <= '0;
            pend_full <= 1'b0;
        end else begin
            if (apply) begin
                act_half  <= pend_half;
                act_dead  <= pend_dead;
                pend_full <= 1'b0;
            end
            if (xfer && cfg_ok) begin
                pend_half <= cfg_half;
                pend_dead <= cfg_dead;
                pend_full <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
